max_fwd_group_arbiter: RTL and testbench
========================================

# max_fwd_group_arbiter

Group-level arbiter placed in front of the softmax max-forwarding stage. It lets two row producers share the single forwarding unit and never interleaves rows of different groups. Each group is locked to one requester from its first row to its last. The block counts rows per group from the length mode and tags every forwarded row with source, first and last flags.

## Interface
- DATA_W, 16, width of a row's local max (signed two's complement, passed through unmodified)
- MODE_W, 4, width of length_mode
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  global enable; low freezes all state and outputs
- i_req0_valid  in  1  requester 0 row valid
- i_req0_loc_max  in  DATA_W  requester 0 row local max
- i_req0_length_mode  in  MODE_W  requester 0 group length mode
- o_req0_ready  out  1  requester 0 row accepted this cycle when valid&ready
- i_req1_valid / i_req1_loc_max / i_req1_length_mode / o_req1_ready  same as requester 0
- o_valid_max  out  1  forwarded row valid (to forwarding i_valid_max)
- o_loc_max  out  DATA_W  forwarded local max
- o_length_mode  out  MODE_W  group length mode (latched at first row)
- o_src_id  out  1  requester that owns the row
- o_first  out  1  first row of group
- o_last  out  1  last row of group
- o_mode_err  out  1  sticky: length_mode changed inside a group, or illegal mode 14/15

## Operation
- Group length: mode 0,1,2 → 1 row (bypass); mode 3..13 → mode−1 rows (2..12); modes 14,15 → 1 row and set o_mode_err.
- States: IDLE, LOCKED. Registers: owner, rr_ptr, mode_q, rows_left (4 bits).
- IDLE: if i_en and any valid, select requester: the one whose valid is high if only one; else rr_ptr. Selected ready=1 combinationally, other ready=0. Handshake loads mode_q, rows_left=len−1, owner=sel. If len==1, the group ends: stay IDLE, rr_ptr=~sel. Else go to LOCKED.
- LOCKED: only owner's ready=1 (while i_en); other ready=0. Each handshake decrements rows_left. The handshake with rows_left==1 is the last row → IDLE, rr_ptr=~owner.
- Owner valid low in LOCKED: no transfer, o_valid_max=0 that cycle, lock held indefinitely.
- Rows after the first use mode_q. If the requester's length_mode≠mode_q on a handshake, set o_mode_err. Group length is not altered.
- o_mode_err clears only on reset.

## Timing
- All outputs registered. A handshake in cycle N gives o_valid_max=1 with that row's data/flags in cycle N+1. Otherwise o_valid_max=0 in N+1.
- Back-to-back groups: the last row of group A and the first row of group B may be accepted in consecutive cycles (no bubble).
- Single-row group: o_first=o_last=1.
- i_en=0: ready both 0, no state change, all outputs hold previous value (including o_valid_max).
- Reset values: o_valid_max=0, o_loc_max=0, o_length_mode=0, o_src_id=0, o_first=0, o_last=0, o_mode_err=0, ready both 0, state=IDLE, rr_ptr=0, rows_left=0.
- Reset mid-group: group discarded; no further rows of it forwarded; arbitration restarts at requester 0.
- Ready depends combinationally on valids, i_en and state only; no path from outputs.

## Configuration
- MAX_FWD_ARB_GROUP_GAP_EN defined: after each group's last handshake, one mandatory idle cycle (both ready=0, o_valid_max=0 in the following output cycle) before the next grant. The rr_ptr update is unchanged.
- Undefined: groups are gap-less as described above.

## Test plan
- Single requester, req0, mode 3, rows 100,101 → two outputs: first=1/last=0 then first=0/last=1, src=0, mode=3, each 1 cycle after its handshake.
- Both valid continuously: req0 mode 4 (3 rows), req1 mode 13 (12 rows) → req0's 3 rows, then req1's 12 rows uninterrupted, then req0 again. o_src_id never changes mid-group.
- Bypass modes 0 and 1 alternating on both requesters → strict alternation 0,1,0,1; every output has first=last=1.
- req1 owns a mode 5 group and drops valid after row 2 for 3 cycles while req0 is valid → req0 ready stays 0; req1 rows 3,4 complete the group; then req0 is granted.
- Mode changes 6→7 at row 2 → o_mode_err=1 from the next cycle and stays 1; the group still ends after 5 rows. Mode 15 → 1-row group, o_mode_err=1.
- Assert i_rst during row 4 of a mode 13 group → all outputs 0 asynchronously. After release, a mode 3 group from req1 alone completes normally. With MAX_FWD_ARB_GROUP_GAP_EN, exactly one o_valid_max=0 cycle appears between back-to-back groups.

Source files
------------

// File: rtl/max_fwd_group_arbiter.sv
// max_fwd_group_arbiter
// Group-level arbiter in front of the softmax max-forwarding stage. Two row
// producers share one forwarding unit; a group is locked to its requester from
// first row to last, so rows of different groups never interleave.
//
// Ports:
//   i_clk, i_rst              clock (rising edge), async active-high reset
//   i_en                      global enable; low freezes state and outputs
//   i_reqN_valid/_loc_max/_length_mode, o_reqN_ready   requester N (N=0,1)
//   o_valid_max, o_loc_max    forwarded row (registered, one cycle after handshake)
//   o_length_mode, o_src_id   group length mode and owning requester
//   o_first, o_last           group boundary flags
//   o_mode_err                sticky: mode change inside a group or mode 14/15
//
// Optional feature: define MAX_FWD_ARB_GROUP_GAP_EN to insert one mandatory idle
// cycle after each group's last handshake before the next grant.
module max_fwd_group_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MODE_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_loc_max,
  input  logic [MODE_W-1:0] i_req0_length_mode,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_loc_max,
  input  logic [MODE_W-1:0] i_req1_length_mode,
  output logic              o_req1_ready,
  output logic              o_valid_max,
  output logic [DATA_W-1:0] o_loc_max,
  output logic [MODE_W-1:0] o_length_mode,
  output logic              o_src_id,
  output logic              o_first,
  output logic              o_last,
  output logic              o_mode_err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Rows per group: 3..13 -> mode-1 rows, everything else is a one-row group.
  function automatic logic [CNT_W-1:0] grp_len(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] dec;
    dec = m - MODE_W'(1);
    if (m >= MODE_W'(3) && m <= MODE_W'(13)) grp_len = CNT_W'(dec);
    else                                     grp_len = CNT_W'(1);
  endfunction

  function automatic logic mode_illegal(input logic [MODE_W-1:0] m);
    mode_illegal = (m >= MODE_W'(14));
  endfunction

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  rows_left_q, rows_left_d;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] loc_max_q, loc_max_d;
  logic [MODE_W-1:0] length_mode_q, length_mode_d;
  logic              src_id_q, src_id_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              mode_err_q, mode_err_d;

  logic              gap_blk_c;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
  logic              gap_q, gap_d;
  assign gap_blk_c = gap_q;
`else
  assign gap_blk_c = 1'b0;
`endif

  logic              sel_c;
  logic              src_c;
  logic              ready0_c, ready1_c;
  logic              hs_c;
  logic [MODE_W-1:0] in_mode_c;
  logic [DATA_W-1:0] in_data_c;
  logic [CNT_W-1:0]  len_c;

  // Arbitration and ready: depends only on valids, enable and registered state.
  always_comb begin
    sel_c    = rr_ptr_q;
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    if (i_req0_valid && !i_req1_valid)      sel_c = 1'b0;
    else if (i_req1_valid && !i_req0_valid) sel_c = 1'b1;

    src_c = (state_q == ST_LOCKED) ? owner_q : sel_c;

    if (i_en) begin
      if (state_q == ST_LOCKED) begin
        ready0_c = !owner_q;
        ready1_c = owner_q;
      end else if (!gap_blk_c && (i_req0_valid || i_req1_valid)) begin
        ready0_c = !sel_c;
        ready1_c = sel_c;
      end
    end

    hs_c      = (ready0_c && i_req0_valid) || (ready1_c && i_req1_valid);
    in_mode_c = src_c ? i_req1_length_mode : i_req0_length_mode;
    in_data_c = src_c ? i_req1_loc_max     : i_req0_loc_max;
    len_c     = grp_len(in_mode_c);
  end

  assign o_req0_ready = ready0_c;
  assign o_req1_ready = ready1_c;

  // Next-state and registered output computation.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    mode_d        = mode_q;
    rows_left_d   = rows_left_q;
    valid_d       = valid_q;
    loc_max_d     = loc_max_q;
    length_mode_d = length_mode_q;
    src_id_d      = src_id_q;
    first_d       = first_q;
    last_d        = last_q;
    mode_err_d    = mode_err_q;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
    gap_d         = gap_q;
`endif

    if (i_en) begin
      valid_d = hs_c;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
      gap_d   = 1'b0;
`endif
      if (hs_c) begin
        loc_max_d = in_data_c;
        src_id_d  = src_c;
        case (state_q)
          ST_IDLE: begin
            mode_d        = in_mode_c;
            length_mode_d = in_mode_c;
            owner_d       = src_c;
            rows_left_d   = len_c - CNT_W'(1);
            first_d       = 1'b1;
            last_d        = (len_c == CNT_W'(1));
            if (mode_illegal(in_mode_c)) mode_err_d = 1'b1;
            if (len_c == CNT_W'(1)) begin
              rr_ptr_d = !src_c;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
              gap_d    = 1'b1;
`endif
            end else begin
              state_d = ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            length_mode_d = mode_q;
            rows_left_d   = rows_left_q - CNT_W'(1);
            first_d       = 1'b0;
            last_d        = (rows_left_q == CNT_W'(1));
            // Group length stays as latched; a changed mode only flags an error.
            if (in_mode_c != mode_q) mode_err_d = 1'b1;
            if (rows_left_q == CNT_W'(1)) begin
              state_d  = ST_IDLE;
              rr_ptr_d = !owner_q;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
              gap_d    = 1'b1;
`endif
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      rr_ptr_q      <= 1'b0;
      mode_q        <= '0;
      rows_left_q   <= '0;
      valid_q       <= 1'b0;
      loc_max_q     <= '0;
      length_mode_q <= '0;
      src_id_q      <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      mode_err_q    <= 1'b0;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
      gap_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      mode_q        <= mode_d;
      rows_left_q   <= rows_left_d;
      valid_q       <= valid_d;
      loc_max_q     <= loc_max_d;
      length_mode_q <= length_mode_d;
      src_id_q      <= src_id_d;
      first_q       <= first_d;
      last_q        <= last_d;
      mode_err_q    <= mode_err_d;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
      gap_q         <= gap_d;
`endif
    end
  end

  assign o_valid_max   = valid_q;
  assign o_loc_max     = loc_max_q;
  assign o_length_mode = length_mode_q;
  assign o_src_id      = src_id_q;
  assign o_first       = first_q;
  assign o_last        = last_q;
  assign o_mode_err    = mode_err_q;

endmodule

// File: tb/tb_max_fwd_group_arbiter.sv
// Self-checking bench for max_fwd_group_arbiter: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a
// group-counting reference model.
module tb_max_fwd_group_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        v0, v1;
  logic [15:0] d0, d1;
  logic [3:0]  m0, m1;
  logic        r0, r1;
  logic        o_valid, o_src, o_first, o_last, o_err;
  logic [15:0] o_data;
  logic [3:0]  o_mode;

  int n_checks = 0;
  int n_errors = 0;

  max_fwd_group_arbiter #(.DATA_W(16), .MODE_W(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_en               (en),
    .i_req0_valid       (v0),
    .i_req0_loc_max     (d0),
    .i_req0_length_mode (m0),
    .o_req0_ready       (r0),
    .i_req1_valid       (v1),
    .i_req1_loc_max     (d1),
    .i_req1_length_mode (m1),
    .o_req1_ready       (r1),
    .o_valid_max        (o_valid),
    .o_loc_max          (o_data),
    .o_length_mode      (o_mode),
    .o_src_id           (o_src),
    .o_first            (o_first),
    .o_last             (o_last),
    .o_mode_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the current group as "owner + rows still to come"; -1 owner = free.
  int          m_owner;
  int          m_left;
  int          m_rr;
  int          m_gmode;
  bit          m_gap;
  bit          m_valid, m_src, m_first, m_last, m_err;
  logic [15:0] m_data;
  logic [3:0]  m_mode;

  function automatic int rows_of(input int mode);
    return (mode >= 3 && mode <= 13) ? mode - 1 : 1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_rr = 0; m_gmode = 0; m_gap = 0;
    m_valid = 0; m_src = 0; m_first = 0; m_last = 0; m_err = 0;
    m_data = '0; m_mode = '0;
  endtask

  task automatic model_ready(output bit er0, output bit er1);
    er0 = 0; er1 = 0;
    if (en) begin
      if (m_owner == 0) er0 = 1;
      else if (m_owner == 1) er1 = 1;
      else if (!m_gap) begin
        if (v0 && v1) begin er0 = (m_rr == 0); er1 = (m_rr == 1); end
        else if (v0) er0 = 1;
        else if (v1) er1 = 1;
      end
    end
  endtask

  task automatic model_clock(input bit er0, input bit er1);
    bit hs0, hs1;
    int s, mode;
    if (!en) return;
    m_gap = 0;
    hs0 = er0 && v0;
    hs1 = er1 && v1;
    m_valid = hs0 || hs1;
    if (!m_valid) return;
    s    = hs1 ? 1 : 0;
    mode = s ? int'(m1) : int'(m0);
    m_data = s ? d1 : d0;
    m_src  = s[0];
    if (m_owner < 0) begin
      m_gmode = mode;
      m_mode  = 4'(mode);
      m_first = 1;
      m_left  = rows_of(mode) - 1;
      if (mode >= 14) m_err = 1;
    end else begin
      m_mode  = 4'(m_gmode);
      m_first = 0;
      if (mode != m_gmode) m_err = 1;
      m_left--;
    end
    m_last = (m_left == 0);
    if (m_last) begin
      m_owner = -1;
      m_rr    = 1 - s;
`ifdef MAX_FWD_ARB_GROUP_GAP_EN
      m_gap   = 1;
`endif
    end else begin
      m_owner = s;
    end
  endtask

  task automatic check_outputs_vs_model();
    chk("valid_max", 32'(o_valid), 32'(m_valid));
    chk("loc_max",   32'(o_data),  32'(m_data));
    chk("length_mode", 32'(o_mode), 32'(m_mode));
    chk("src_id",    32'(o_src),   32'(m_src));
    chk("first",     32'(o_first), 32'(m_first));
    chk("last",      32'(o_last),  32'(m_last));
    chk("mode_err",  32'(o_err),   32'(m_err));
  endtask

  // Drive one cycle from the negedge, check ready, clock, check outputs.
  task automatic run_cycle(input bit e, input bit a0, input logic [3:0] mm0, input logic [15:0] dd0,
                           input bit a1, input logic [3:0] mm1, input logic [15:0] dd1);
    bit er0, er1;
    en = e; v0 = a0; m0 = mm0; d0 = dd0; v1 = a1; m1 = mm1; d1 = dd1;
    #1;
    model_ready(er0, er1);
    chk("ready0", 32'(r0), 32'(er0));
    chk("ready1", 32'(r1), 32'(er1));
    @(posedge clk);
    model_clock(er0, er1);
    #1;
    check_outputs_vs_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 0; v0 = 0; v1 = 0; m0 = 0; m1 = 0; d0 = 0; d1 = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          en;
    bit          v0;
    logic [3:0]  m0;
    logic [15:0] d0;
    bit          v1;
    logic [3:0]  m1;
    logic [15:0] d1;
    bit          r0;
    bit          r1;
    bit          val;
    logic [15:0] dat;
    logic [3:0]  md;
    bit          src;
    bit          first;
    bit          last;
    bit          err;
  } vec_t;

  vec_t tv[10];

  initial begin
    logic [15:0] cnt;
    logic [3:0]  rm0, rm1;

    rst = 1; en = 0; v0 = 0; v1 = 0; m0 = 0; m1 = 0; d0 = 0; d1 = 0;
    model_reset();

    //          en v0 m0 d0         v1 m1 d1         r0 r1 val dat        md src f  l  err
    tv[0] = '{1, 1, 4'd3, 16'd100,  0, 4'd0, 16'd0,   1, 0, 1, 16'd100,   4'd3, 0, 1, 0, 0};
    tv[1] = '{1, 1, 4'd3, 16'd101,  0, 4'd0, 16'd0,   1, 0, 1, 16'd101,   4'd3, 0, 0, 1, 0};
    tv[2] = '{1, 0, 4'd0, 16'd0,    0, 4'd0, 16'd0,   0, 0, 0, 16'd101,   4'd3, 0, 0, 1, 0};
    tv[3] = '{0, 1, 4'd0, 16'd7,    0, 4'd0, 16'd0,   0, 0, 0, 16'd101,   4'd3, 0, 0, 1, 0};
    tv[4] = '{1, 0, 4'd0, 16'd0,    1, 4'd0, 16'hFFFB,0, 1, 1, 16'hFFFB,  4'd0, 1, 1, 1, 0};
    tv[5] = '{0, 1, 4'd0, 16'd1,    1, 4'd0, 16'd2,   0, 0, 1, 16'hFFFB,  4'd0, 1, 1, 1, 0};
    tv[6] = '{1, 0, 4'd0, 16'd0,    0, 4'd0, 16'd0,   0, 0, 0, 16'hFFFB,  4'd0, 1, 1, 1, 0};
    tv[7] = '{1, 1, 4'd15, 16'd9,   0, 4'd0, 16'd0,   1, 0, 1, 16'd9,     4'd15, 0, 1, 1, 1};
    tv[8] = '{1, 0, 4'd0, 16'd0,    0, 4'd0, 16'd0,   0, 0, 0, 16'd9,     4'd15, 0, 1, 1, 1};
    tv[9] = '{1, 1, 4'd2, 16'd10,   1, 4'd0, 16'd11,  0, 1, 1, 16'd11,    4'd0, 1, 1, 1, 1};

    // Reset values while reset is held.
    #2;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_mode",  32'(o_mode),  32'd0);
    chk("rst_src",   32'(o_src),   32'd0);
    chk("rst_first", 32'(o_first), 32'd0);
    chk("rst_last",  32'(o_last),  32'd0);
    chk("rst_err",   32'(o_err),   32'd0);
    chk("rst_ready0", 32'(r0), 32'd0);
    chk("rst_ready1", 32'(r1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      en = tv[i].en; v0 = tv[i].v0; m0 = tv[i].m0; d0 = tv[i].d0;
      v1 = tv[i].v1; m1 = tv[i].m1; d1 = tv[i].d1;
      #1;
      chk($sformatf("tv%0d_ready0", i), 32'(r0), 32'(tv[i].r0));
      chk($sformatf("tv%0d_ready1", i), 32'(r1), 32'(tv[i].r1));
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_valid", i), 32'(o_valid), 32'(tv[i].val));
      chk($sformatf("tv%0d_data", i),  32'(o_data),  32'(tv[i].dat));
      chk($sformatf("tv%0d_mode", i),  32'(o_mode),  32'(tv[i].md));
      chk($sformatf("tv%0d_src", i),   32'(o_src),   32'(tv[i].src));
      chk($sformatf("tv%0d_first", i), 32'(o_first), 32'(tv[i].first));
      chk($sformatf("tv%0d_last", i),  32'(o_last),  32'(tv[i].last));
      chk($sformatf("tv%0d_err", i),   32'(o_err),   32'(tv[i].err));
      @(negedge clk);
    end

    // Both requesters valid continuously: req0 mode 4, req1 mode 13.
    do_reset();
    cnt = 16'd0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1, 1, 4'd4, cnt, 1, 4'd13, cnt + 16'h1000);
      cnt++;
    end

    // Bypass modes 0/1 on both requesters: strict alternation.
    do_reset();
    for (int i = 0; i < 8; i++)
      run_cycle(1, 1, 4'(i % 2), 16'(200 + i), 1, 4'((i + 1) % 2), 16'(300 + i));

    // req1 owns a mode 5 group, stalls for 3 cycles while req0 waits.
    do_reset();
    run_cycle(1, 0, 4'd3, 16'd0, 1, 4'd5, 16'd1);
    run_cycle(1, 1, 4'd3, 16'd50, 1, 4'd5, 16'd2);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 1, 4'd3, 16'd50, 0, 4'd5, 16'd0);
      chk("stall_ready0", 32'(r0), 32'd0);
    end
    run_cycle(1, 1, 4'd3, 16'd50, 1, 4'd5, 16'd3);
    run_cycle(1, 1, 4'd3, 16'd50, 1, 4'd5, 16'd4);
    chk("stall_grp_last", 32'(o_last), 32'd1);
    run_cycle(1, 1, 4'd3, 16'd51, 0, 4'd5, 16'd0);
    run_cycle(1, 1, 4'd3, 16'd52, 0, 4'd5, 16'd0);
    run_cycle(1, 1, 4'd3, 16'd53, 0, 4'd5, 16'd0);

    // Mode change 6 -> 7 inside a 5-row group, then a mode 15 group.
    do_reset();
    run_cycle(1, 1, 4'd6, 16'd1, 0, 4'd0, 16'd0);
    run_cycle(1, 1, 4'd7, 16'd2, 0, 4'd0, 16'd0);
    chk("mchg_err", 32'(o_err), 32'd1);
    for (int i = 3; i <= 5; i++) run_cycle(1, 1, 4'd7, 16'(i), 0, 4'd0, 16'd0);
    chk("mchg_last_row5", 32'(o_last), 32'd1);
    run_cycle(1, 0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    run_cycle(1, 1, 4'd15, 16'd77, 0, 4'd0, 16'd0);
    run_cycle(1, 0, 4'd0, 16'd0, 0, 4'd0, 16'd0);

    // Reset during row 4 of a mode 13 group, then req1 alone completes mode 3.
    do_reset();
    for (int i = 1; i <= 3; i++) run_cycle(1, 1, 4'd13, 16'(i), 0, 4'd0, 16'd0);
    en = 1; v0 = 1; m0 = 4'd13; d0 = 16'd4;
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_data",  32'(o_data),  32'd0);
    chk("arst_first", 32'(o_first), 32'd0);
    chk("arst_last",  32'(o_last),  32'd0);
    chk("arst_mode",  32'(o_mode),  32'd0);
    v0 = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    run_cycle(1, 0, 4'd0, 16'd0, 1, 4'd3, 16'd31);
    run_cycle(1, 0, 4'd0, 16'd0, 1, 4'd3, 16'd32);
    chk("post_rst_last", 32'(o_last), 32'd1);
    run_cycle(1, 0, 4'd0, 16'd0, 0, 4'd3, 16'd0);

    // Randomized traffic against the model.
    do_reset();
    rm0 = 4'd4; rm1 = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) rm0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rm1 = 4'($urandom_range(0, 15));
      run_cycle($urandom_range(0, 9) != 0,
                $urandom_range(0, 3) != 0, rm0, 16'($urandom),
                $urandom_range(0, 3) != 0, rm1, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
